apb_req_master: RTL and testbench
=================================

Name: apb_req_master

Overview:
- Upstream master stage that drives the APB interface.
- Converts a simple valid/ready request channel and a valid/ready response channel into single APB transfers (SETUP then ACCESS).
- Sits between a core-side bus adapter and the APB slave side (address decoder or peripherals).
- Handles one transfer at a time; all APB outputs are registered.

Parameters:
- AddrWidth, 32, width of req_addr_i and paddr_o
- DataWidth, 32, width of write/read data; must be a multiple of 8
- StrbWidth, DataWidth/8, derived; byte-strobe width
- TimeoutCycles, 256, ACCESS-phase cycle limit before abort (used only with the optional feature); must be >= 1

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_addr_i  in  AddrWidth  transfer address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DataWidth  write data
- req_strb_i  in  StrbWidth  write byte strobes
- req_prot_i  in  3  protection attributes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_rdata_o  out  DataWidth  read data; 0 for writes
- rsp_err_o  out  1  slave error (or timeout)
- paddr_o  out  AddrWidth  APB address
- pprot_o  out  3  APB protection
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  DataWidth  APB write data
- pstrb_o  out  StrbWidth  APB strobes
- prdata_i  in  DataWidth  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset values:
  - FSM = IDLE.
  - All outputs 0, including paddr/pwdata/pstrb/pprot, rsp_rdata and rsp_err.
  - Reset mid-transfer drops psel/penable immediately (asynchronously) and discards the pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1; in no other state.
  - On req_valid_i: latch addr, write, wdata, strb, prot into the APB output registers; go to SETUP.
  - Read requests: pstrb_o and pwdata_o are driven 0.
- SETUP (one cycle): psel_o=1, penable_o=0; go to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; wait for pready_i.
  - On pready_i: register rsp_rdata_o = (read ? prdata_i : 0) and rsp_err_o = pslverr_i.
  - Then deassert psel/penable and go to RESP.
- RESP:
  - rsp_valid_o=1; rsp_rdata/rsp_err are held stable until rsp_ready_i.
  - On handshake go to IDLE and clear rsp_valid_o.
  - rsp_rdata/rsp_err keep their last value until overwritten.
- APB address/control/data stay stable from SETUP through the final ACCESS cycle, as APB requires.
- pready_i and pslverr_i are ignored outside ACCESS; prdata_i is sampled only in the pready cycle.
- Latency, with the request accepted in cycle 0:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - With pready=1 in cycle 2, rsp_valid_o=1 in cycle 3.
  - Each wait state adds one cycle.
- Throughput: at most one transfer per 4 cycles, since a new request is accepted only in IDLE. No bypass and no overlap.
- A simultaneous req_valid_i while in RESP is held off (req_ready_o=0).

Optional Feature:
- Macro: APB_REQ_MASTER_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TimeoutCycles+1) clears on SETUP entry and increments each ACCESS cycle without pready.
  - If it reaches TimeoutCycles with pready still low: deassert psel/penable next cycle, enter RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - pready arriving in the same cycle the count is reached wins (a normal completion).
  - A later stray pready is ignored.
- When undefined: no counter logic exists; ACCESS waits indefinitely.

Decomposition:
- Package apb_req_master_pkg holds:
  - state enum state_e {IDLE, SETUP, ACCESS, RESP}
  - prot_t (logic[2:0])
  - PROT_DEFAULT = 3'b000 constant
- Width-dependent addr/data/strb types are declared locally from the parameters.
- No sub-module: a single module with the FSM, the output registers and the optional counter is natural.

Test Plan:
- Write addr=0x1000_0040, wdata=0xDEADBEEF, strb=0xF, pready tied 1:
  - SETUP in cycle 1 (psel=1, penable=0), ACCESS in cycle 2.
  - rsp_valid in cycle 3 with err=0, rdata=0.
- Read addr=0x1000_0044, slave inserts 3 wait states then prdata=0x12345678:
  - penable held for 4 cycles, all APB signals stable throughout.
  - rsp_rdata=0x12345678; pstrb=0 during the transfer.
- Read with pslverr=1 on the pready cycle: rsp_err=1 and rsp_rdata=prdata.
- rsp_ready held 0 for 5 cycles: rsp_valid and rsp data held stable, req_ready=0; the next request is accepted only after the handshake.
- rst_i asserted during ACCESS: psel/penable/rsp_valid drop to 0 without a clock edge; after release the FSM is in IDLE with req_ready=1.
- With APB_REQ_MASTER_TIMEOUT_EN, TimeoutCycles=4, pready held 0:
  - Abort after 4 ACCESS cycles with rsp_err=1, rdata=0.
  - A pready arriving afterwards is ignored.

Source files
------------

// File: rtl/apb_req_master_pkg.sv
//------------------------------------------------------------------------------
// Module   : apb_req_master_pkg
// Brief    : Shared state encoding, protection type and defaults for apb_req_master.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package apb_req_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef logic [2:0] prot_t;

    localparam prot_t PROT_DEFAULT = 3'b000;

endpackage

`default_nettype wire

// File: rtl/apb_req_master.sv
//------------------------------------------------------------------------------
// Module   : apb_req_master
// Brief    : Valid/ready request/response channel to single APB transfers.
//            Optional ACCESS timeout: define APB_REQ_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_strb_i,
    input  logic [2:0]            req_prot_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [2:0]            pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    if ((DATA_WIDTH % 8 != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("apb_req_master: illegal DATA_WIDTH or TIMEOUT_CYCLES");
    end

    state_e r_state;
    state_e w_state_next;
    logic   w_accept;
    logic   w_done;
    logic   w_timeout;
    logic   w_to_hit;

    logic   r_req_ready;
    logic   r_rsp_valid;
    data_t  r_rsp_rdata;
    logic   r_rsp_err;
    addr_t  r_paddr;
    prot_t  r_pprot;
    logic   r_psel;
    logic   r_penable;
    logic   r_pwrite;
    data_t  r_pwdata;
    strb_t  r_pstrb;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Abort fires in the TIMEOUT_CYCLES-th ACCESS cycle that still sees no pready.
    assign w_to_hit = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == ACCESS) && !pready_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid_i && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = SETUP;
                end
            end
            SETUP: w_state_next = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    w_done       = 1'b1;
                    w_state_next = RESP;
                end else if (w_to_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // req_ready is registered so it reads 0 while reset is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_paddr     <= '0;
            r_pprot     <= PROT_DEFAULT;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
        end else begin
            r_req_ready <= (w_state_next == IDLE);
            if (w_accept) begin
                r_paddr  <= req_addr_i;
                r_pprot  <= req_prot_i;
                r_pwrite <= req_write_i;
                r_pwdata <= req_write_i ? req_wdata_i : '0;
                r_pstrb  <= req_write_i ? req_strb_i : '0;
                r_psel   <= 1'b1;
            end
            if (r_state == SETUP) begin
                r_penable <= 1'b1;
            end
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
                r_rsp_err   <= pslverr_i;
            end
            if (w_timeout) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
            if (w_done || w_timeout) begin
                r_psel      <= 1'b0;
                r_penable   <= 1'b0;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == RESP) && rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign paddr_o     = r_paddr;
    assign pprot_o     = r_pprot;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign pwdata_o    = r_pwdata;
    assign pstrb_o     = r_pstrb;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_master.sv
//------------------------------------------------------------------------------
// Module   : tb_apb_req_master
// Brief    : Randomized self-checking bench for apb_req_master against a
//            transaction-level model. Honors APB_REQ_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_req_master;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    localparam int c_TO = 4;
`else
    localparam int c_TO = 256;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_strb_i = '0;
    logic [2:0]  req_prot_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] paddr_o;
    logic [2:0]  pprot_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    apb_req_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .STRB_WIDTH     (4),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_strb_i  (req_strb_i),
        .req_prot_i  (req_prot_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .paddr_o     (paddr_o),
        .pprot_o     (pprot_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Expected APB view of one transfer, taken from the request as issued.
    task automatic check_apb(input string tag, input logic en, input logic [31:0] a, input logic w,
                             input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
        check_eq({tag, "_psel"},      psel_o,      1'b1);
        check_eq({tag, "_penable"},   penable_o,   en);
        check_eq({tag, "_paddr"},     paddr_o,     a);
        check_eq({tag, "_pwrite"},    pwrite_o,    w);
        check_eq({tag, "_pwdata"},    pwdata_o,    wd);
        check_eq({tag, "_pstrb"},     pstrb_o,     st);
        check_eq({tag, "_pprot"},     pprot_o,     pr);
        check_eq({tag, "_req_ready"}, req_ready_o, 1'b0);
        check_eq({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
    endtask

    // Full transfer: waits = wait states before pready, hold = cycles rsp_ready stays low.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input int waits,
                           input logic err, input logic [31:0] rd, input int hold);
        logic [31:0] e_wd;
        logic [3:0]  e_st;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_to;
        int          n_acc;
        e_wd  = w ? wd : 32'h0;
        e_st  = w ? st : 4'h0;
        n_acc = waits + 1;
        e_to  = 1'b0;
        if (waits >= c_TO) begin
            n_acc = c_TO;
            e_to  = 1'b1;
        end
        e_rd  = e_to ? 32'h0 : (w ? 32'h0 : rd);
        e_err = e_to ? 1'b1 : err;

        check_eq("idle_req_ready", req_ready_o, 1'b1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_write_i = w;
        req_wdata_i = wd;
        req_strb_i  = st;
        req_prot_i  = pr;
        next_cycle();
        req_valid_i = 1'($urandom);
        req_addr_i  = $urandom;
        req_write_i = 1'($urandom);
        req_wdata_i = $urandom;
        req_strb_i  = 4'($urandom);
        req_prot_i  = 3'($urandom);
        check_apb("setup", 1'b0, a, w, e_wd, e_st, pr);
        pready_i  = 1'($urandom);
        pslverr_i = 1'($urandom);
        prdata_i  = $urandom;
        for (int i = 0; i < n_acc; i++) begin
            next_cycle();
            check_apb("access", 1'b1, a, w, e_wd, e_st, pr);
            if (i == waits) begin
                pready_i  = 1'b1;
                pslverr_i = err;
                prdata_i  = rd;
            end else begin
                pready_i  = 1'b0;
                pslverr_i = 1'($urandom);
                prdata_i  = $urandom;
            end
        end
        next_cycle();
        for (int j = 0; j <= hold; j++) begin
            check_eq("resp_valid",     rsp_valid_o, 1'b1);
            check_eq("resp_psel",      psel_o,      1'b0);
            check_eq("resp_penable",   penable_o,   1'b0);
            check_eq("resp_rdata",     rsp_rdata_o, e_rd);
            check_eq("resp_err",       rsp_err_o,   e_err);
            check_eq("resp_req_ready", req_ready_o, 1'b0);
            pready_i    = 1'($urandom);
            pslverr_i   = 1'($urandom);
            prdata_i    = $urandom;
            req_valid_i = 1'($urandom);
            rsp_ready_i = (j == hold);
            next_cycle();
        end
        check_eq("done_rsp_valid",  rsp_valid_o, 1'b0);
        check_eq("done_req_ready",  req_ready_o, 1'b1);
        check_eq("done_psel",       psel_o,      1'b0);
        check_eq("done_rdata_kept", rsp_rdata_o, e_rd);
        check_eq("done_err_kept",   rsp_err_o,   e_err);
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_i);
        @(negedge clk_i);
        check_eq("rst_req_ready", req_ready_o, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid_o, 1'b0);
        check_eq("rst_psel",      psel_o,      1'b0);
        check_eq("rst_penable",   penable_o,   1'b0);
        check_eq("rst_paddr",     paddr_o,     32'h0);
        check_eq("rst_pwdata",    pwdata_o,    32'h0);
        check_eq("rst_pstrb",     pstrb_o,     4'h0);
        check_eq("rst_pprot",     pprot_o,     3'h0);
        check_eq("rst_pwrite",    pwrite_o,    1'b0);
        check_eq("rst_rdata",     rsp_rdata_o, 32'h0);
        check_eq("rst_err",       rsp_err_o,   1'b0);
        rst_i = 1'b0;
        next_cycle();

        run_txn(32'h1000_0040, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'hAAAA_5555, 0);
        run_txn(32'h1000_0044, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'd2, 3, 1'b0, 32'h1234_5678, 0);
        run_txn(32'h1000_0048, 1'b0, 32'h0,         4'h0, 3'd1, 1, 1'b1, 32'hCAFE_F00D, 0);
        run_txn(32'h1000_004C, 1'b1, 32'h0BAD_CAFE, 4'h5, 3'd7, 2, 1'b0, 32'h0,         5);

        // Asynchronous reset in the middle of ACCESS.
        req_valid_i = 1'b1;
        req_addr_i  = 32'h2000_0000;
        req_write_i = 1'b0;
        next_cycle();
        req_valid_i = 1'b0;
        next_cycle();
        check_eq("pre_rst_penable", penable_o, 1'b1);
        #1 rst_i = 1'b1;
        #1;
        check_eq("arst_psel",      psel_o,      1'b0);
        check_eq("arst_penable",   penable_o,   1'b0);
        check_eq("arst_rsp_valid", rsp_valid_o, 1'b0);
        check_eq("arst_paddr",     paddr_o,     32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        next_cycle();
        check_eq("post_rst_req_ready", req_ready_o, 1'b1);
        check_eq("post_rst_rsp_valid", rsp_valid_o, 1'b0);

`ifdef APB_REQ_MASTER_TIMEOUT_EN
        run_txn(32'h3000_0000, 1'b0, 32'h0, 4'h0, 3'd0, 20, 1'b0, 32'h7777_7777, 2);
        run_txn(32'h3000_0004, 1'b1, 32'h1, 4'h1, 3'd0, c_TO - 1, 1'b0, 32'h0, 0);
`endif

        for (int k = 0; k < 150; k++) begin
            int idle_gap;
            run_txn($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                    int'($urandom_range(0, 6)), 1'($urandom), $urandom,
                    int'($urandom_range(0, 3)));
            idle_gap = int'($urandom_range(0, 2));
            for (int g = 0; g < idle_gap; g++) begin
                next_cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
